// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings and defaults for the two-requester basic_ram port arbiter.
package ram_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    localparam logic OWN_M0      = 1'b0;
    localparam logic OWN_M1      = 1'b1;
    localparam int   DEF_TIMEOUT = 15;

    // Width able to hold 0..timeout inclusive.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way combinational pick: round-robin against last_owner, or m0-first when fixed_pri is set.
module rr_arbiter2
    import ram_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    input  logic       i_fixed_pri,
    output logic       o_grant,
    output logic       o_valid
);

    // Winner selection; only a tie consults the priority policy.
    always_comb begin
        o_valid = |i_req;
        o_grant = OWN_M0;
        case (i_req)
            2'b01:   o_grant = OWN_M0;
            2'b10:   o_grant = OWN_M1;
            2'b11:   o_grant = i_fixed_pri ? OWN_M0 : ~i_last_owner;
            default: o_grant = OWN_M0;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one basic_ram port between m0 (loader/DMA) and m1 (core): arbitrates per access,
// holds the winner's command on the RAM until mem_done or timeout, then pulses ack/err.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d_in,
    input  logic [DATA_W-1:0] ram_d_out,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    input  logic              ram_mem_done,
    output logic              busy,
    output logic              owner
);

    localparam int               CNT_W       = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(TIMEOUT);
    localparam logic             FIXED_PRI_L = (FIXED_PRI != 0);

    arb_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last_owner;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_cs;
    logic                r_ram_we;
    logic                r_ram_oe;
    logic                r_busy;
    logic [1:0]          r_ack;
    logic [1:0]          r_err;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    arb_state_t          w_state;
    logic [CNT_W-1:0]    w_cnt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_last_owner;
    logic                w_owner;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_cs;
    logic                w_ram_we;
    logic                w_ram_oe;
    logic                w_busy;
    logic [1:0]          w_ack;
    logic [1:0]          w_err;
    logic [DATA_W-1:0]   w_rdata0;
    logic [DATA_W-1:0]   w_rdata1;
    logic                w_grant;
    logic                w_grant_valid;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_arbiter2 u_arb (
        .i_req        ({m1_req, m0_req}),
        .i_last_owner (r_last_owner),
        .i_fixed_pri  (FIXED_PRI_L),
        .o_grant      (w_grant),
        .o_valid      (w_grant_valid)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Command of the port that wins arbitration this cycle.
    always_comb begin
        if (w_grant == OWN_M1) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end else begin
            w_sel_we    = m0_we;
            w_sel_addr  = m0_addr;
            w_sel_wdata = m0_wdata;
        end
    end

    // Next-state and next-output logic; RAM strobes are computed one cycle ahead so they are flopped.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_last_owner = r_last_owner;
        w_owner      = r_owner;
        w_we         = r_we;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_cs         = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_oe     = 1'b0;
        w_busy       = 1'b0;
        w_ack        = 2'b00;
        w_err        = 2'b00;
        w_rdata0     = r_rdata0;
        w_rdata1     = r_rdata1;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state  = ST_ACCESS;
                    w_cnt    = {CNT_W{1'b0}};
                    w_owner  = w_grant;
                    w_we     = w_sel_we;
                    w_addr   = w_sel_addr;
                    w_wdata  = w_sel_wdata;
                    w_cs     = 1'b1;
                    w_ram_we = w_sel_we;
                    w_ram_oe = ~w_sel_we;
                    w_busy   = 1'b1;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ram_mem_done) begin
                    w_state          = ST_IDLE;
                    w_last_owner     = r_owner;
                    w_ack[r_owner]   = 1'b1;
                    if (r_we) begin
                        w_rdata0 = r_rdata0;
                        w_rdata1 = r_rdata1;
                    end else if (r_owner == OWN_M1) begin
                        w_rdata1 = ram_d_out;
                    end else begin
                        w_rdata0 = ram_d_out;
                    end
                end else if (w_cnt_inc == CNT_LIMIT) begin
                    w_state        = ST_IDLE;
                    w_last_owner   = r_owner;
                    w_err[r_owner] = 1'b1;
                end else begin
                    w_cnt    = w_cnt_inc;
                    w_cs     = 1'b1;
                    w_ram_we = r_we;
                    w_ram_oe = ~r_we;
                    w_busy   = 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves m1 as last owner so m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_last_owner <= OWN_M1;
            r_owner      <= OWN_M0;
            r_we         <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_cs         <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
            r_rdata0     <= {DATA_W{1'b0}};
            r_rdata1     <= {DATA_W{1'b0}};
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_last_owner <= w_last_owner;
            r_owner      <= w_owner;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_cs         <= w_cs;
            r_ram_we     <= w_ram_we;
            r_ram_oe     <= w_ram_oe;
            r_busy       <= w_busy;
            r_ack        <= w_ack;
            r_err        <= w_err;
            r_rdata0     <= w_rdata0;
            r_rdata1     <= w_rdata1;
        end
    end

    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign m0_ack   = r_ack[0];
    assign m1_ack   = r_ack[1];
    assign m0_err   = r_err[0];
    assign m1_err   = r_err[1];
    assign ram_addr = r_addr;
    assign ram_d_in = r_wdata;
    assign ram_cs   = r_cs;
    assign ram_we   = r_ram_we;
    assign ram_oe   = r_ram_oe;
    assign busy     = r_busy;
    assign owner    = r_owner;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: instance a is round-robin, instance b fixed-priority;
// a small RAM model answers each, and a scoreboard matches every ack/err pulse.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

    logic        a_m0_req, a_m1_req, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_ram_addr, a_ram_d_in, a_ram_d_out;
    logic        a_ram_cs, a_ram_we, a_ram_oe, a_mem_done, a_busy, a_owner;

    logic        b_m0_req, b_m1_req, b_m0_ack, b_m1_ack, b_m0_err, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_d_in, b_ram_d_out;
    logic        b_ram_cs, b_ram_we, b_ram_oe, b_mem_done, b_busy, b_owner;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulse_a = -1;
    int          pulse_b = -1;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    int          cyc_a = 0;
    int          cyc_b = 0;
    int          lat_a = 1;
    int          lat_b = 1;
    logic        en_a = 1'b1;
    logic        en_b = 1'b1;
    logic        stray_a = 1'b0;

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .FIXED_PRI(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req(a_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_err(a_m0_err),
        .m1_req(a_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_err(a_m1_err),
        .ram_addr(a_ram_addr), .ram_d_in(a_ram_d_in), .ram_d_out(a_ram_d_out),
        .ram_cs(a_ram_cs), .ram_we(a_ram_we), .ram_oe(a_ram_oe),
        .ram_mem_done(a_mem_done), .busy(a_busy), .owner(a_owner)
    );

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .FIXED_PRI(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
        .m1_req(b_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
        .ram_addr(b_ram_addr), .ram_d_in(b_ram_d_in), .ram_d_out(b_ram_d_out),
        .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_oe(b_ram_oe),
        .ram_mem_done(b_mem_done), .busy(b_busy), .owner(b_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: mem_done arrives lat cycles after cs rises; writes land on the done edge.
    assign a_mem_done  = (a_ram_cs && en_a && (cyc_a == lat_a)) || stray_a;
    assign b_mem_done  = b_ram_cs && en_b && (cyc_b == lat_b);
    assign a_ram_d_out = mem_a[a_ram_addr[7:0]];
    assign b_ram_d_out = mem_b[b_ram_addr[7:0]];

    always @(posedge clk) begin
        cyc_a <= a_ram_cs ? cyc_a + 1 : 0;
        cyc_b <= b_ram_cs ? cyc_b + 1 : 0;
        if (a_ram_cs && a_ram_we && a_mem_done) mem_a[a_ram_addr[7:0]] <= a_ram_d_in;
        if (b_ram_cs && b_ram_we && b_mem_done) mem_b[b_ram_addr[7:0]] <= b_ram_d_in;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit inst, input logic port, input logic err, input logic [31:0] rd);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        if (inst) sb_b.push_back(e);
        else      sb_a.push_back(e);
    endtask

    task automatic mon(input bit inst);
        logic [3:0]  p;
        logic [31:0] r0, r1;
        logic        port;
        exp_t        e;
        string       px;
        int          pulse;
        px    = inst ? "b" : "a";
        pulse = -1;
        if (inst) begin
            p  = {b_m1_err, b_m1_ack, b_m0_err, b_m0_ack};
            r0 = b_m0_rdata;
            r1 = b_m1_rdata;
        end else begin
            p  = {a_m1_err, a_m1_ack, a_m0_err, a_m0_ack};
            r0 = a_m0_rdata;
            r1 = a_m1_rdata;
        end
        if (p != 4'b0000) begin
            chk({px, "_one_pulse"}, 64'($countones(p)), 64'd1);
            port  = p[3] | p[2];
            pulse = int'(port);
            if ((inst && sb_b.size() == 0) || (!inst && sb_a.size() == 0)) begin
                chk({px, "_unexpected_pulse"}, 64'(p), 64'd0);
            end else begin
                if (inst) e = sb_b.pop_front();
                else      e = sb_a.pop_front();
                chk({px, "_port"}, 64'(port), 64'(e.port));
                chk({px, "_is_err"}, 64'(port ? p[3] : p[1]), 64'(e.err));
                chk({px, "_rdata"}, 64'(port ? r1 : r0), 64'(e.rdata));
            end
        end
        if (inst) pulse_b = pulse;
        else      pulse_a = pulse;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mon(1'b0);
        mon(1'b1);
    endtask

    task automatic wait_pulse(input bit inst, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if ((inst ? pulse_b : pulse_a) >= 0) return;
        end
        chk(inst ? "b_wait_timeout" : "a_wait_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int n;
        int cs_cycles;
        rst = 1'b1;
        a_m0_req = 1'b0; a_m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
        m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", 64'(a_ram_cs), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_owner", 64'(a_owner), 64'd0);
        chk("rst_pulses", 64'({a_m0_ack, a_m0_err, a_m1_ack, a_m1_err}), 64'd0);
        chk("rst_rdata", 64'(a_m0_rdata), 64'd0);
        rst = 1'b0;
        step();

        // 1: m0 write, mem_done one cycle after cs -> ack in cycle 3
        m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hCAFEF00D; lat_a = 1;
        a_m0_req = 1'b1;
        push(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t1_cs", 64'(a_ram_cs), 64'd1);
        chk("t1_we", 64'(a_ram_we), 64'd1);
        chk("t1_oe", 64'(a_ram_oe), 64'd0);
        chk("t1_addr", 64'(a_ram_addr), 64'h10);
        chk("t1_din", 64'(a_ram_d_in), 64'hCAFEF00D);
        chk("t1_busy", 64'(a_busy), 64'd1);
        chk("t1_owner", 64'(a_owner), 64'd0);
        step();
        chk("t1_no_early_ack", 64'(a_m0_ack), 64'd0);
        step();
        chk("t1_ack_cycle3", 64'(a_m0_ack), 64'd1);
        chk("t1_cs_drop", 64'(a_ram_cs), 64'd0);
        a_m0_req = 1'b0;

        // 2: m1 read back with mem_done in the first access cycle (minimum latency)
        m1_we = 1'b0; m1_addr = 32'h10; lat_a = 0;
        a_m1_req = 1'b1;
        push(1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
        step();
        chk("t2_cs", 64'(a_ram_cs), 64'd1);
        chk("t2_we", 64'(a_ram_we), 64'd0);
        chk("t2_oe", 64'(a_ram_oe), 64'd1);
        chk("t2_owner", 64'(a_owner), 64'd1);
        step();
        chk("t2_ack_cycle2", 64'(a_m1_ack), 64'd1);
        a_m1_req = 1'b0;

        // 3: simultaneous held requests from reset; a alternates, b keeps m0
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat_a = 1; lat_b = 1;
        m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h11111111;
        m1_we = 1'b1; m1_addr = 32'h21; m1_wdata = 32'h22222222;
        a_m0_req = 1'b1; a_m1_req = 1'b1; b_m0_req = 1'b1; b_m1_req = 1'b1;
        push(1'b0, 1'b0, 1'b0, 32'h0); push(1'b0, 1'b1, 1'b0, 32'h0);
        push(1'b0, 1'b0, 1'b0, 32'h0); push(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 32'h0);
        push(1'b1, 1'b1, 1'b0, 32'h0);
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            step();
            if (pulse_a >= 0) begin
                n++;
                chk("t3_idle_gap", 64'(a_ram_cs), 64'd0);
                if (n == 4) begin
                    a_m0_req = 1'b0; a_m1_req = 1'b0; b_m0_req = 1'b0;
                end
            end
        end
        chk("t3_grant_count", 64'(n), 64'd4);
        wait_pulse(1'b1, 10);
        b_m1_req = 1'b0;
        chk("t3b_owner_m1", 64'(b_owner), 64'd1);

        // 4: good m1 read, then a timed-out read that must keep the old rdata
        m1_we = 1'b0; m1_addr = 32'h21;
        a_m1_req = 1'b1;
        push(1'b0, 1'b1, 1'b0, 32'h22222222);
        wait_pulse(1'b0, 10);
        a_m1_req = 1'b0;
        en_a = 1'b0; m1_addr = 32'h20;
        a_m1_req = 1'b1;
        push(1'b0, 1'b1, 1'b1, 32'h22222222);
        cs_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pulse_a >= 0) break;
            if (a_ram_cs) cs_cycles++;
        end
        chk("t4_access_cycles", 64'(cs_cycles), 64'd15);
        chk("t4_err", 64'(a_m1_err), 64'd1);
        chk("t4_no_ack", 64'(a_m1_ack), 64'd0);
        chk("t4_cs_off", 64'(a_ram_cs), 64'd0);
        chk("t4_rdata_kept", 64'(a_m1_rdata), 64'h22222222);
        a_m1_req = 1'b0; en_a = 1'b1;

        // 5: reset in the second access cycle, then the held request is served
        lat_a = 3; m0_we = 1'b0; m0_addr = 32'h20;
        a_m0_req = 1'b1;
        step();
        step();
        chk("t5_cs_before", 64'(a_ram_cs), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_strobes", 64'({a_ram_cs, a_ram_we, a_ram_oe}), 64'd0);
        chk("t5_async_busy", 64'(a_busy), 64'd0);
        step();
        rst = 1'b0;
        push(1'b0, 1'b0, 1'b0, 32'h11111111);
        wait_pulse(1'b0, 20);
        a_m0_req = 1'b0;

        // 6: m0 drops req mid-access, pending m1 follows after one idle cycle
        m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h33333333;
        a_m0_req = 1'b1;
        push(1'b0, 1'b0, 1'b0, 32'h11111111);
        step();
        chk("t6_owner_m0", 64'(a_owner), 64'd0);
        m1_we = 1'b0; m1_addr = 32'h30;
        a_m1_req = 1'b1;
        step();
        a_m0_req = 1'b0;
        wait_pulse(1'b0, 10);
        chk("t6_m0_acked", 64'(pulse_a), 64'd0);
        chk("t6_idle_gap", 64'(a_ram_cs), 64'd0);
        push(1'b0, 1'b1, 1'b0, 32'h33333333);
        step();
        chk("t6_m1_granted", 64'(a_owner), 64'd1);
        chk("t6_m1_cs", 64'(a_ram_cs), 64'd1);
        wait_pulse(1'b0, 10);
        a_m1_req = 1'b0;

        // 7: stray mem_done while idle must not start or finish anything
        stray_a = 1'b1;
        step();
        step();
        chk("t7_idle_busy", 64'(a_busy), 64'd0);
        chk("t7_idle_cs", 64'(a_ram_cs), 64'd0);
        stray_a = 1'b0;
        step();

        chk("a_scoreboard_empty", 64'(sb_a.size()), 64'd0);
        chk("b_scoreboard_empty", 64'(sb_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
